// File: rtl/cp_strip_pkg.sv
// ============================================================================
// Module      : cp_strip_pkg
// Description : Shared state encodings and OFDM framing defaults for TX and RX.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cp_strip_pkg;

  localparam int c_DW      = 12;
  localparam int c_PRE_LEN = 320;
  localparam int c_CP_LEN  = 16;
  localparam int c_FFT_LEN = 64;
  localparam int c_NUM_SYM = 100;
  localparam int c_CP_ADV  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SKIP = 2'd1,
    ST_CP   = 2'd2,
    ST_DATA = 2'd3
  } state_t;

  // One sample counter serves all phases, so it must hold the longest one.
  function automatic int cnt_width(input int pre_len, input int cp_len, input int fft_len);
    int m;
    m = pre_len;
    if (cp_len > m) m = cp_len;
    if (fft_len > m) m = fft_len;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cp_strip_cnt.sv
// ============================================================================
// Module      : cp_strip_cnt
// Description : Loadable sample counter with a terminal-count flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp_strip_cnt
  import cp_strip_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (inc) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt = r_cnt;
  assign tc  = (r_cnt == term);

endmodule

`default_nettype wire

// File: rtl/cp_strip.sv
// ============================================================================
// Module      : cp_strip
// Description : Skips the preamble, strips each cyclic prefix and forwards the
//               FFT_LEN useful samples of every OFDM symbol with framing.
//               Macro CP_ADV_EN advances the FFT window by CP_ADV samples.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp_strip
  import cp_strip_pkg::*;
#(
  parameter int DW      = c_DW,
  parameter int PRE_LEN = c_PRE_LEN,
  parameter int CP_LEN  = c_CP_LEN,
  parameter int FFT_LEN = c_FFT_LEN,
  parameter int NUM_SYM = c_NUM_SYM,
  parameter int CP_ADV  = c_CP_ADV
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] di_re,
  input  logic [DW-1:0] di_im,
  input  logic          packet_start,
  output logic [DW-1:0] do_re,
  output logic [DW-1:0] do_im,
  output logic          do_valid,
  output logic          sym_start,
  output logic          sym_last,
  output logic          pkt_done,
  output logic          busy
);

  localparam int c_SYM_W = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1;
  localparam int c_CNT_W = cnt_width(PRE_LEN, CP_LEN, FFT_LEN);

`ifdef CP_ADV_EN
  // Only the first prefix is shortened; the symbol period stays CP_LEN+FFT_LEN,
  // so every later window keeps the same early offset.
  localparam int c_CP_FIRST = CP_LEN - CP_ADV;
  generate
    if (CP_ADV >= CP_LEN || CP_ADV < 0) begin : g_cp_adv_chk
      $error("cp_strip: CP_ADV must be in [0, CP_LEN)");
    end
  endgenerate
`else
  localparam int c_CP_FIRST = CP_LEN;
  generate
    if (CP_ADV < 0) begin : g_cp_adv_chk
      $error("cp_strip: CP_ADV must be non-negative");
    end
  endgenerate
`endif

  generate
    if (PRE_LEN < 2 || CP_LEN < 1 || FFT_LEN < 1 || NUM_SYM < 1) begin : g_len_chk
      $error("cp_strip: framing lengths out of range");
    end
  endgenerate

  localparam logic [c_CNT_W-1:0] c_PRE_TC  = c_CNT_W'(PRE_LEN - 1);
  localparam logic [c_CNT_W-1:0] c_CPF_TC  = c_CNT_W'(c_CP_FIRST - 1);
  localparam logic [c_CNT_W-1:0] c_CP_TC   = c_CNT_W'(CP_LEN - 1);
  localparam logic [c_CNT_W-1:0] c_FFT_TC  = c_CNT_W'(FFT_LEN - 1);
  localparam logic [c_SYM_W-1:0] c_SYM_TC  = c_SYM_W'(NUM_SYM - 1);

  state_t               r_state;
  logic [c_SYM_W-1:0]   r_symcnt;
  logic [DW-1:0]        r_do_re;
  logic [DW-1:0]        r_do_im;
  logic                 r_do_valid;
  logic                 r_sym_start;
  logic                 r_sym_last;
  logic                 r_pkt_done;
  logic                 r_busy;

  logic [c_CNT_W-1:0]   w_scnt;
  logic [c_CNT_W-1:0]   w_term;
  logic [c_CNT_W-1:0]   w_load_val;
  logic                 w_tc;
  logic                 w_accept;
  logic                 w_load;
  logic                 w_inc;

  // A start pulse landing on the pkt_done cycle belongs to the old packet.
  assign w_accept   = (r_state == ST_IDLE) && packet_start && !r_pkt_done;
  assign w_load     = w_accept || ((r_state != ST_IDLE) && w_tc);
  assign w_load_val = w_accept ? c_CNT_W'(1) : '0;
  assign w_inc      = (r_state != ST_IDLE);

  always_comb begin
    w_term = '0;
    case (r_state)
      ST_SKIP: w_term = c_PRE_TC;
      ST_CP:   w_term = (r_symcnt == '0) ? c_CPF_TC : c_CP_TC;
      ST_DATA: w_term = c_FFT_TC;
      default: w_term = '0;
    endcase
  end

  cp_strip_cnt #(
    .W (c_CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .inc      (w_inc),
    .term     (w_term),
    .cnt      (w_scnt),
    .tc       (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_symcnt    <= '0;
      r_do_re     <= '0;
      r_do_im     <= '0;
      r_do_valid  <= 1'b0;
      r_sym_start <= 1'b0;
      r_sym_last  <= 1'b0;
      r_pkt_done  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_do_valid  <= 1'b0;
      r_sym_start <= 1'b0;
      r_sym_last  <= 1'b0;
      r_pkt_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_busy <= w_accept;
          if (w_accept) begin
            r_state <= ST_SKIP;
          end
        end
        ST_SKIP: begin
          if (w_tc) begin
            r_state <= ST_CP;
          end
        end
        ST_CP: begin
          if (w_tc) begin
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          r_do_valid  <= 1'b1;
          r_do_re     <= di_re;
          r_do_im     <= di_im;
          r_sym_start <= (w_scnt == '0);
          r_sym_last  <= w_tc;
          if (w_tc) begin
            if (r_symcnt == c_SYM_TC) begin
              r_state    <= ST_IDLE;
              r_pkt_done <= 1'b1;
              r_symcnt   <= '0;
            end else begin
              r_state  <= ST_CP;
              r_symcnt <= r_symcnt + c_SYM_W'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign do_re     = r_do_re;
  assign do_im     = r_do_im;
  assign do_valid  = r_do_valid;
  assign sym_start = r_sym_start;
  assign sym_last  = r_sym_last;
  assign pkt_done  = r_pkt_done;
  assign busy      = r_busy;

endmodule

`default_nettype wire

// File: doc/cp_strip.md
Name: cp_strip

Overview:
- Receiver stage directly downstream of PSU.
- Consumes PSU's sample stream (do_re/do_im) and its packet_start pulse.
- Skips the preamble, then for each OFDM symbol discards the cyclic prefix and emits the FFT_LEN useful samples with framing strobes to the FFT.
- Counts symbols and returns to idle after NUM_SYM symbols.

Parameters:
- DW, 12, sample width per I/Q component
- PRE_LEN, 320, preamble samples following packet_start, inclusive of the packet_start sample
- CP_LEN, 16, cyclic-prefix samples per symbol
- FFT_LEN, 64, useful samples per symbol
- NUM_SYM, 100, data symbols per packet
- CP_ADV, 4, samples of early FFT-window advance; used only with CP_ADV_EN

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- di_re  in  DW  PSU real sample, one per clk
- di_im  in  DW  PSU imaginary sample
- packet_start  in  1  one-cycle pulse coincident with the first preamble sample on di_*
- do_re  out  DW  useful sample, real
- do_im  out  DW  useful sample, imaginary
- do_valid  out  1  do_* holds a useful sample
- sym_start  out  1  first useful sample of a symbol
- sym_last  out  1  last useful sample of a symbol
- pkt_done  out  1  one-cycle pulse with sym_last of symbol NUM_SYM-1
- busy  out  1  high from the cycle after packet_start until pkt_done

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters 0. rst is sampled on clk only. rst mid-packet aborts with no pkt_done.
- Input handling: one input sample per clk, no backpressure. Outputs registered, latency exactly 1 clk from di_* to do_*.
- Sample counter: scnt. Symbol counter: symcnt, width clog2(NUM_SYM).
- IDLE:
  - packet_start=1 -> SKIP, scnt=1, since the packet_start sample is preamble sample 0.
- SKIP:
  - scnt increments.
  - When scnt==PRE_LEN-1 -> CP, scnt=0.
- CP:
  - Drop CP_LEN samples.
  - On scnt==CP_LEN-1 -> DATA, scnt=0.
- DATA:
  - Pass FFT_LEN samples with do_valid=1.
  - sym_start on scnt==0; sym_last on scnt==FFT_LEN-1.
  - At scnt==FFT_LEN-1:
    - If symcnt==NUM_SYM-1 -> IDLE, assert pkt_done with sym_last, symcnt=0.
    - Otherwise symcnt+1 -> CP.
- do_re/do_im when do_valid=0: hold the last value. The bench must not check them.
- packet_start while busy: ignored. No restart and no counter disturbance.
- packet_start in the same cycle the FSM enters IDLE (after pkt_done): ignored. IDLE acts on packet_start only from the following cycle.
- Data is passed unmodified. No arithmetic and no width change.

Optional Feature:
- Macro: CP_ADV_EN.
- Defined:
  - CP state drops only CP_LEN-CP_ADV samples.
  - DATA window therefore starts CP_ADV samples early and still spans FFT_LEN samples.
  - CP_ADV must be < CP_LEN; violation is a compile-time $error.
- Undefined: window starts exactly at the CP end, and CP_ADV is unused.

Decomposition:
- Shared package/include (alongside the global defines): state encodings IDLE/SKIP/CP/DATA, and defaults for PRE_LEN/CP_LEN/FFT_LEN/NUM_SYM so TX and RX agree.
- One natural sub-module, cp_strip_cnt: the loadable, terminal-count sample counter, instantiated once and reused across SKIP/CP/DATA.

Test Plan:
- Nominal packet: drive di_re=di_im=sample index k (k=0 at packet_start) for 320+100*80 samples.
  - First do_valid one clk after k=336 arrives, with do_re=336 and sym_start=1.
  - sym_last at do_re=399.
  - Total 6400 valid samples.
  - pkt_done with do_re=8319.
- Symbol boundaries: check that do_re never takes values 320..335 or 400..415.
  - In general, no k with (k-320) mod 80 < 16 appears.
- Spurious packet_start: pulse at k=1000 and at k=5000 during a packet.
  - Output identical to the nominal run; busy stays 1.
- Reset mid-packet: assert rst for one clk at k=2000.
  - Next cycle all outputs 0, no pkt_done.
  - A new packet_start 10 clks later yields a nominal packet.
- Back-to-back: second packet_start 1 clk after pkt_done.
  - It is accepted, and the second packet matches nominal.
  - A packet_start coincident with pkt_done is ignored.
- CP_ADV_EN defined, CP_ADV=4: first valid sample do_re=332, first sym_last do_re=395, pkt_done at do_re=8315.
